// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for a five-stage in-order core. It decides, every
// cycle, which pipeline registers hold (stall) and which get a bubble (flush).
// It also supervises the multi-cycle (mul/div) unit with a watchdog.
//
// Stall and flush outputs are combinational from the current inputs and the
// registered FSM state. They therefore act on the same clock edge that the
// hazard is seen on.
//
// Resolution order when several conditions are active in one cycle:
//   trap > mem_busy > multi-cycle > redirect > load-use
//
// Parameters
//   MC_MAX_CYCLES  watchdog limit for one multi-cycle op, legal range 2..256.
//
// Optional feature
//   COTM32_HAZARD_PERF_EN  when defined, builds a 32-bit free-running count of
//                          cycles with o_pc_stall=1 on o_stall_cycles.
//                          Otherwise o_stall_cycles is tied to 0 and no
//                          counter flops are built.
//
// Ports
//   i_clk            clock, all state on the rising edge
//   i_rst_n          synchronous active-low reset
//   i_id_*           ID-stage instruction: valid, rs1/rs2 index, rs1/rs2 used
//   i_ex_valid       EX holds a valid instruction
//   i_ex_rd          EX destination register index
//   i_ex_is_load     EX instruction is a load
//   i_ex_mc_start    EX holds an incomplete multi-cycle op
//   i_mc_done        multi-cycle result ready (one-cycle pulse)
//   i_ex_redirect    taken branch / jump resolved in EX
//   i_trap           trap or mret commit request
//   i_mem_busy       LSU waiting on memory
//   o_*_stall        hold PC / IF-ID / ID-EX / EX-MEM
//   o_*_flush        bubble into IF-ID / ID-EX / EX-MEM
//   o_mc_abort       one-cycle kill of the multi-cycle unit
//   o_mc_timeout     sticky watchdog-expired flag, cleared only by reset
//   o_state          FSM state (0 RUN, 1 MC_WAIT)
//   o_stall_cycles   PC-stall cycle counter (0 unless perf counter is built)
//
// FSM states
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   RUN      | normal issue; multi-cycle op not outstanding
//   MC_WAIT  | EX is held waiting for i_mc_done, the watchdog is counting
// -----------------------------------------------------------------------------

module hazard_ctrl #(
    parameter int MC_MAX_CYCLES = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_id_valid,
    input  logic [4:0]  i_id_rs1,
    input  logic [4:0]  i_id_rs2,
    input  logic        i_id_use_rs1,
    input  logic        i_id_use_rs2,
    input  logic        i_ex_valid,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_is_load,
    input  logic        i_ex_mc_start,
    input  logic        i_mc_done,
    input  logic        i_ex_redirect,
    input  logic        i_trap,
    input  logic        i_mem_busy,
    output logic        o_pc_stall,
    output logic        o_ifid_stall,
    output logic        o_idex_stall,
    output logic        o_exmem_stall,
    output logic        o_ifid_flush,
    output logic        o_idex_flush,
    output logic        o_exmem_flush,
    output logic        o_mc_abort,
    output logic        o_mc_timeout,
    output logic [1:0]  o_state,
    output logic [31:0] o_stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MC_WAIT = 2'd1
    } state_t;

    // Counter values never exceed MC_MAX_CYCLES-1 (at most 255), so 8 bits
    // cover the whole legal parameter range.
    localparam logic [7:0] WD_LAST = 8'(MC_MAX_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_wd_cnt;
    logic [7:0] w_wd_cnt_nxt;
    logic       r_mc_timeout;
    logic       w_mc_timeout_nxt;

    logic       w_in_wait;
    logic       w_mc_enter;
    logic       w_wd_expire;
    logic       w_rs1_hit;
    logic       w_rs2_hit;
    logic       w_load_use;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign w_in_wait   = (r_state == ST_MC_WAIT);

    // A multi-cycle op whose result is already available in its first EX
    // cycle needs no wait at all.
    assign w_mc_enter  = (r_state == ST_RUN) && i_ex_mc_start && !i_mc_done;

    assign w_wd_expire = w_in_wait && !i_mc_done && (r_wd_cnt == WD_LAST);

    // x0 is hardwired to zero, so a load targeting it can never be a hazard.
    assign w_rs1_hit   = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit   = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    assign w_load_use  = i_ex_valid && i_ex_is_load && (i_ex_rd != 5'd0) &&
                         i_id_valid && (w_rs1_hit || w_rs2_hit);

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_pc_stall       = 1'b0;
        o_ifid_stall     = 1'b0;
        o_idex_stall     = 1'b0;
        o_exmem_stall    = 1'b0;
        o_ifid_flush     = 1'b0;
        o_idex_flush     = 1'b0;
        o_exmem_flush    = 1'b0;
        o_mc_abort       = 1'b0;
        w_state_nxt      = r_state;
        w_wd_cnt_nxt     = r_wd_cnt;
        w_mc_timeout_nxt = r_mc_timeout;

        if (!i_rst_n) begin
            // Outputs stay quiet while reset is asserted; the registers
            // reload themselves in the sequential block.
            w_state_nxt      = ST_RUN;
            w_wd_cnt_nxt     = 8'd0;
            w_mc_timeout_nxt = 1'b0;
        end else if (i_trap) begin
            o_ifid_flush  = 1'b1;
            o_idex_flush  = 1'b1;
            o_exmem_flush = 1'b1;
            // Only kill the multi-cycle unit if something is actually in it.
            o_mc_abort    = w_in_wait || i_ex_mc_start;
            w_state_nxt   = ST_RUN;
            w_wd_cnt_nxt  = 8'd0;
        end else if (i_mem_busy) begin
            // Full freeze: state and watchdog hold so a memory wait does not
            // count against the multi-cycle budget.
            o_pc_stall    = 1'b1;
            o_ifid_stall  = 1'b1;
            o_idex_stall  = 1'b1;
            o_exmem_stall = 1'b1;
        end else if (w_in_wait) begin
            if (i_mc_done) begin
                w_state_nxt  = ST_RUN;
                w_wd_cnt_nxt = 8'd0;
            end else if (w_wd_expire) begin
                // Give up on the op: drop it out of ID-EX and resume issue.
                o_mc_abort       = 1'b1;
                o_idex_flush     = 1'b1;
                w_mc_timeout_nxt = 1'b1;
                w_state_nxt      = ST_RUN;
                w_wd_cnt_nxt     = 8'd0;
            end else begin
                o_pc_stall    = 1'b1;
                o_ifid_stall  = 1'b1;
                o_idex_stall  = 1'b1;
                o_exmem_flush = 1'b1;
                w_wd_cnt_nxt  = r_wd_cnt + 8'd1;
            end
        end else if (w_mc_enter) begin
            // The entry cycle already counts as the first waited cycle.
            o_pc_stall    = 1'b1;
            o_ifid_stall  = 1'b1;
            o_idex_stall  = 1'b1;
            o_exmem_flush = 1'b1;
            w_state_nxt   = ST_MC_WAIT;
            w_wd_cnt_nxt  = 8'd1;
        end else if (i_ex_redirect) begin
            // EX is not stalled here, so the redirect is taken now and the
            // two younger instructions are squashed.
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end else if (w_load_use) begin
            o_pc_stall   = 1'b1;
            o_ifid_stall = 1'b1;
            o_idex_flush = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_RUN;
            r_wd_cnt     <= 8'd0;
            r_mc_timeout <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wd_cnt     <= w_wd_cnt_nxt;
            r_mc_timeout <= w_mc_timeout_nxt;
        end
    end

    assign o_state      = r_state;
    assign o_mc_timeout = r_mc_timeout;

    // ------------------------------------------------------------------
    // Optional stall-cycle performance counter
    // ------------------------------------------------------------------
`ifdef COTM32_HAZARD_PERF_EN
    logic [31:0] r_stall_cycles;

    // Wraps naturally from all-ones to zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stall_cycles <= 32'd0;
        end else if (o_pc_stall) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`else
    assign o_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int MC = 8;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_id_valid;
    logic [4:0]  i_id_rs1;
    logic [4:0]  i_id_rs2;
    logic        i_id_use_rs1;
    logic        i_id_use_rs2;
    logic        i_ex_valid;
    logic [4:0]  i_ex_rd;
    logic        i_ex_is_load;
    logic        i_ex_mc_start;
    logic        i_mc_done;
    logic        i_ex_redirect;
    logic        i_trap;
    logic        i_mem_busy;
    logic        o_pc_stall;
    logic        o_ifid_stall;
    logic        o_idex_stall;
    logic        o_exmem_stall;
    logic        o_ifid_flush;
    logic        o_idex_flush;
    logic        o_exmem_flush;
    logic        o_mc_abort;
    logic        o_mc_timeout;
    logic [1:0]  o_state;
    logic [31:0] o_stall_cycles;

    hazard_ctrl #(.MC_MAX_CYCLES(MC)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_id_valid     (i_id_valid),
        .i_id_rs1       (i_id_rs1),
        .i_id_rs2       (i_id_rs2),
        .i_id_use_rs1   (i_id_use_rs1),
        .i_id_use_rs2   (i_id_use_rs2),
        .i_ex_valid     (i_ex_valid),
        .i_ex_rd        (i_ex_rd),
        .i_ex_is_load   (i_ex_is_load),
        .i_ex_mc_start  (i_ex_mc_start),
        .i_mc_done      (i_mc_done),
        .i_ex_redirect  (i_ex_redirect),
        .i_trap         (i_trap),
        .i_mem_busy     (i_mem_busy),
        .o_pc_stall     (o_pc_stall),
        .o_ifid_stall   (o_ifid_stall),
        .o_idex_stall   (o_idex_stall),
        .o_exmem_stall  (o_exmem_stall),
        .o_ifid_flush   (o_ifid_flush),
        .o_idex_flush   (o_idex_flush),
        .o_exmem_flush  (o_exmem_flush),
        .o_mc_abort     (o_mc_abort),
        .o_mc_timeout   (o_mc_timeout),
        .o_state        (o_state),
        .o_stall_cycles (o_stall_cycles)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Control vector order: pc, ifid, idex, exmem stall | ifid, idex, exmem flush | abort
    logic [7:0] act;
    assign act = {o_pc_stall, o_ifid_stall, o_idex_stall, o_exmem_stall,
                  o_ifid_flush, o_idex_flush, o_exmem_flush, o_mc_abort};

    localparam logic [7:0] C_NONE  = 8'b0000_0000;
    localparam logic [7:0] C_LU    = 8'b1100_0100;
    localparam logic [7:0] C_MC    = 8'b1110_0010;
    localparam logic [7:0] C_MEM   = 8'b1111_0000;
    localparam logic [7:0] C_TRAPA = 8'b0000_1111;
    localparam logic [7:0] C_TRAP  = 8'b0000_1110;
    localparam logic [7:0] C_WDOG  = 8'b0000_0101;
    localparam logic [7:0] C_REDIR = 8'b0000_1100;

    // ---------------- behavioural reference model ----------------
    bit          m_busy_mc;     // a multi-cycle op is outstanding
    int          m_waited;      // cycles spent on the outstanding op so far
    bit          m_timeout;
    logic [31:0] m_perf;

    function automatic bit m_load_use();
        return i_ex_valid && i_ex_is_load && (i_ex_rd != 0) && i_id_valid &&
               ((i_id_use_rs1 && i_id_rs1 == i_ex_rd) ||
                (i_id_use_rs2 && i_id_rs2 == i_ex_rd));
    endfunction

    // Expected outputs for this cycle, from the priority list.
    function automatic logic [7:0] m_expect();
        if (!i_rst_n)    return C_NONE;
        if (i_trap)      return (m_busy_mc || i_ex_mc_start) ? C_TRAPA : C_TRAP;
        if (i_mem_busy)  return C_MEM;
        if (m_busy_mc) begin
            if (i_mc_done)          return C_NONE;
            if (m_waited + 1 == MC) return C_WDOG;
            return C_MC;
        end
        if (i_ex_mc_start && !i_mc_done) return C_MC;
        if (i_ex_redirect) return C_REDIR;
        if (m_load_use())  return C_LU;
        return C_NONE;
    endfunction

    task automatic m_advance(input logic [7:0] exp_c);
        if (!i_rst_n) begin
            m_busy_mc = 0; m_waited = 0; m_timeout = 0; m_perf = 0;
            return;
        end
        if (exp_c[7]) m_perf = m_perf + 32'd1;
        if (i_trap) begin
            m_busy_mc = 0; m_waited = 0;
        end else if (i_mem_busy) begin
            // frozen
        end else if (m_busy_mc) begin
            if (i_mc_done) begin
                m_busy_mc = 0; m_waited = 0;
            end else if (m_waited + 1 == MC) begin
                m_busy_mc = 0; m_waited = 0; m_timeout = 1;
            end else begin
                m_waited++;
            end
        end else if (i_ex_mc_start && !i_mc_done) begin
            m_busy_mc = 1; m_waited = 1;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic idle_inputs();
        i_rst_n = 1; i_id_valid = 0; i_id_rs1 = 0; i_id_rs2 = 0;
        i_id_use_rs1 = 0; i_id_use_rs2 = 0; i_ex_valid = 0; i_ex_rd = 0;
        i_ex_is_load = 0; i_ex_mc_start = 0; i_mc_done = 0; i_ex_redirect = 0;
        i_trap = 0; i_mem_busy = 0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst_n = 0;
        tick();
        i_rst_n = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        i_rst_n = 0; i_trap = 1; i_mem_busy = 1; i_ex_mc_start = 1; i_ex_redirect = 1;
        #4;
        checks++;
        if (act !== C_NONE) begin errors++; $display("FAIL reset_outputs act=%b exp=%b", act, C_NONE); end
        tick();
        #4;
        checks++;
        if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state act=%0d exp=0", o_state); end
        checks++;
        if (o_mc_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout act=%b exp=0", o_mc_timeout); end
        checks++;
        if (o_stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_perf act=%0d exp=0", o_stall_cycles); end
        tick();
        // reset while waiting on a multi-cycle op
        idle_inputs();
        i_ex_mc_start = 1;
        tick();
        #4;
        checks++;
        if (o_state !== 2'd1) begin errors++; $display("FAIL rst_wait_enter act=%0d exp=1", o_state); end
        tick();
        i_rst_n = 0;
        #4;
        checks++;
        if (act !== C_NONE) begin errors++; $display("FAIL rst_in_wait_abort act=%b exp=%b", act, C_NONE); end
        tick();
        idle_inputs();
        #4;
        checks++;
        if (o_state !== 2'd0) begin errors++; $display("FAIL rst_in_wait_state act=%0d exp=0", o_state); end
        tick();
    endtask

    task automatic test_load_use();
        idle_inputs();
        i_ex_valid = 1; i_ex_is_load = 1; i_ex_rd = 5'd5;
        i_id_valid = 1; i_id_use_rs2 = 1; i_id_rs2 = 5'd5; i_id_rs1 = 5'd9; i_id_use_rs1 = 1;
        #4;
        checks++;
        if (act !== C_LU) begin errors++; $display("FAIL load_use_x5 act=%b exp=%b", act, C_LU); end
        tick();
        i_ex_rd = 5'd0; i_id_rs2 = 5'd0;
        #4;
        checks++;
        if (act !== C_NONE) begin errors++; $display("FAIL load_use_x0 act=%b exp=%b", act, C_NONE); end
        tick();
        i_ex_rd = 5'd9; i_id_use_rs1 = 0;
        #4;
        checks++;
        if (act !== C_NONE) begin errors++; $display("FAIL load_use_rs1_unused act=%b exp=%b", act, C_NONE); end
        tick();
        idle_inputs();
    endtask

    task automatic test_multicycle();
        idle_inputs();
        i_ex_mc_start = 1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            i_mc_done = (cyc == 4);
            #4;
            checks++;
            if (act !== ((cyc < 4) ? C_MC : C_NONE)) begin
                errors++; $display("FAIL mc_seq_ctl cyc=%0d act=%b", cyc, act);
            end
            if (cyc == 2 || cyc == 3) begin
                checks++;
                if (o_state !== 2'd1) begin errors++; $display("FAIL mc_seq_state cyc=%0d act=%0d exp=1", cyc, o_state); end
            end
            tick();
        end
        idle_inputs();
        #4;
        checks++;
        if (o_state !== 2'd0) begin errors++; $display("FAIL mc_seq_exit act=%0d exp=0", o_state); end
        tick();
        // op finishing in its first EX cycle needs no stall
        i_ex_mc_start = 1; i_mc_done = 1;
        #4;
        checks++;
        if (act !== C_NONE) begin errors++; $display("FAIL mc_immediate act=%b exp=%b", act, C_NONE); end
        tick();
        idle_inputs();
        #4;
        checks++;
        if (o_state !== 2'd0) begin errors++; $display("FAIL mc_immediate_state act=%0d exp=0", o_state); end
        tick();
    endtask

    task automatic test_watchdog();
        idle_inputs();
        i_ex_mc_start = 1;
        for (int cyc = 1; cyc <= MC; cyc++) begin
            #4;
            checks++;
            if (act !== ((cyc < MC) ? C_MC : C_WDOG)) begin
                errors++; $display("FAIL wdog_ctl cyc=%0d act=%b", cyc, act);
            end
            tick();
        end
        i_ex_mc_start = 0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            #4;
            checks++;
            if (o_mc_timeout !== 1'b1) begin errors++; $display("FAIL wdog_sticky cyc=%0d act=%b exp=1", cyc, o_mc_timeout); end
            checks++;
            if (o_state !== 2'd0) begin errors++; $display("FAIL wdog_state cyc=%0d act=%0d exp=0", cyc, o_state); end
            tick();
        end
    endtask

    task automatic test_trap();
        idle_inputs();
        i_trap = 1;
        #4;
        checks++;
        if (act !== C_TRAP) begin errors++; $display("FAIL trap_run act=%b exp=%b", act, C_TRAP); end
        tick();
        idle_inputs();
        i_ex_mc_start = 1;
        tick();
        i_trap = 1; i_mem_busy = 1;
        #4;
        checks++;
        if (act !== C_TRAPA) begin errors++; $display("FAIL trap_wait_membusy act=%b exp=%b", act, C_TRAPA); end
        tick();
        idle_inputs();
        #4;
        checks++;
        if (o_state !== 2'd0) begin errors++; $display("FAIL trap_next_state act=%0d exp=0", o_state); end
        tick();
    endtask

    task automatic test_redirect_load_use();
        idle_inputs();
        i_ex_redirect = 1;
        i_ex_valid = 1; i_ex_is_load = 1; i_ex_rd = 5'd7;
        i_id_valid = 1; i_id_use_rs1 = 1; i_id_rs1 = 5'd7;
        #4;
        checks++;
        if (act !== C_REDIR) begin errors++; $display("FAIL redirect_over_lu act=%b exp=%b", act, C_REDIR); end
        tick();
        idle_inputs();
    endtask

    task automatic test_perf();
        do_reset();
        i_mem_busy = 1;
        repeat (10) tick();
        idle_inputs();
        #4;
        checks++;
`ifdef COTM32_HAZARD_PERF_EN
        if (o_stall_cycles !== 32'd10) begin errors++; $display("FAIL perf_count10 act=%0d exp=10", o_stall_cycles); end
        tick();
        dut.r_stall_cycles = 32'hFFFF_FFFF;
        i_mem_busy = 1;
        tick();
        idle_inputs();
        #4;
        checks++;
        if (o_stall_cycles !== 32'd0) begin errors++; $display("FAIL perf_wrap act=%0d exp=0", o_stall_cycles); end
`else
        if (o_stall_cycles !== 32'd0) begin errors++; $display("FAIL perf_disabled act=%0d exp=0", o_stall_cycles); end
`endif
        tick();
    endtask

    task automatic test_random();
        logic [7:0] exp_c;
        do_reset();
        m_busy_mc = 0; m_waited = 0; m_timeout = 0; m_perf = 0;
        for (int n = 0; n < 3000; n++) begin
            i_rst_n       = ($urandom_range(0, 199) != 0);
            i_trap        = ($urandom_range(0, 99) < 3);
            i_mem_busy    = ($urandom_range(0, 99) < 10);
            i_ex_mc_start = ($urandom_range(0, 99) < 30);
            i_mc_done     = ($urandom_range(0, 99) < 12);
            i_ex_redirect = ($urandom_range(0, 99) < 15);
            i_ex_valid    = ($urandom_range(0, 99) < 80);
            i_ex_is_load  = ($urandom_range(0, 99) < 50);
            i_id_valid    = ($urandom_range(0, 99) < 80);
            i_id_use_rs1  = $urandom_range(0, 1);
            i_id_use_rs2  = $urandom_range(0, 1);
            i_ex_rd       = 5'($urandom_range(0, 3));
            i_id_rs1      = 5'($urandom_range(0, 3));
            i_id_rs2      = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            #4;
            exp_c = m_expect();
            checks++;
            if (act !== exp_c) begin errors++; $display("FAIL rand_ctl n=%0d act=%b exp=%b", n, act, exp_c); end
            checks++;
            if (o_state !== {1'b0, m_busy_mc}) begin errors++; $display("FAIL rand_state n=%0d act=%0d exp=%0d", n, o_state, m_busy_mc); end
            checks++;
            if (o_mc_timeout !== m_timeout) begin errors++; $display("FAIL rand_timeout n=%0d act=%b exp=%b", n, o_mc_timeout, m_timeout); end
            checks++;
`ifdef COTM32_HAZARD_PERF_EN
            if (o_stall_cycles !== m_perf) begin errors++; $display("FAIL rand_perf n=%0d act=%0d exp=%0d", n, o_stall_cycles, m_perf); end
`else
            if (o_stall_cycles !== 32'd0) begin errors++; $display("FAIL rand_perf n=%0d act=%0d exp=0", n, o_stall_cycles); end
`endif
            m_advance(exp_c);
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_final_reset();
        do_reset();
        #4;
        checks++;
        if (o_mc_timeout !== 1'b0 || o_state !== 2'd0) begin
            errors++; $display("FAIL final_reset timeout=%b state=%0d exp 0/0", o_mc_timeout, o_state);
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        i_rst_n = 0;
        repeat (2) @(posedge i_clk);
        #1;
        test_reset();
        test_load_use();
        test_multicycle();
        test_watchdog();
        test_trap();
        test_redirect_load_use();
        test_perf();
        test_random();
        test_final_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout act=running exp=finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MC_MAX_CYCLES, default 64, meaning the multi-cycle watchdog limit in cycles (legal range 2..256).
REQ-002 SHALL have these ports, in this order:
- i_clk  in  1  sole clock; all state updates on its rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_id_valid  in  1  ID holds a valid instruction.
- i_id_rs1  in  5  ID source register 1 index.
- i_id_rs2  in  5  ID source register 2 index.
- i_id_use_rs1  in  1  ID instruction reads rs1.
- i_id_use_rs2  in  1  ID instruction reads rs2.
- i_ex_valid  in  1  EX holds a valid instruction.
- i_ex_rd  in  5  EX destination register index.
- i_ex_is_load  in  1  EX instruction is a load.
- i_ex_mc_start  in  1  EX holds a multi-cycle op (mul/div) that is not yet complete.
- i_mc_done  in  1  multi-cycle unit result ready (single-cycle pulse).
- i_ex_redirect  in  1  taken branch or jump resolved in EX.
- i_trap  in  1  trap or mret commit request.
- i_mem_busy  in  1  LSU waiting on memory.
- o_pc_stall, o_ifid_stall, o_idex_stall, o_exmem_stall  out  1 each  hold the PC / pipeline register.
- o_ifid_flush, o_idex_flush, o_exmem_flush  out  1 each  insert a bubble into the pipeline register.
- o_mc_abort  out  1  one-cycle pulse that kills the multi-cycle unit.
- o_mc_timeout  out  1  sticky watchdog-expired flag.
- o_state  out  2  FSM state (0 RUN, 1 MC_WAIT).
- o_stall_cycles  out  32  performance counter (REQ-016).

Function
REQ-003 All stall and flush outputs SHALL be combinational from the inputs and the registered state, so they take effect at the same clock edge (zero-cycle latency).
REQ-004 Priority SHALL be trap > mem_busy > multi-cycle > redirect > load-use; a lower-priority condition SHALL be suppressed in any cycle where a higher-priority one is active.
REQ-005 Trap (any state): o_ifid_flush=o_idex_flush=o_exmem_flush=1, all stalls 0; next state RUN; the watchdog counter is cleared; o_mc_abort=1 if state is MC_WAIT or i_ex_mc_start=1.
REQ-006 mem_busy, with no trap: all four stalls=1, all flushes=0; state and watchdog counter are held.
REQ-007 RUN with i_ex_mc_start=1 and i_mc_done=0:
- o_pc_stall=o_ifid_stall=o_idex_stall=1 and o_exmem_flush=1;
- next state MC_WAIT; the watchdog counter is loaded to 1.
REQ-008 RUN with i_ex_mc_start=1 and i_mc_done=1: no stall; state remains RUN.
REQ-009 MC_WAIT with i_mc_done=0: same outputs as REQ-007; the watchdog counter increments.
REQ-010 MC_WAIT with i_mc_done=1: all stalls 0, o_exmem_flush=0; next state RUN.
REQ-011 Watchdog: in MC_WAIT with the counter equal to MC_MAX_CYCLES-1 and i_mc_done=0:
- o_mc_abort=1 and o_idex_flush=1, stalls 0;
- o_mc_timeout is set and remains set until reset;
- next state RUN.
REQ-012 Redirect is honoured only when EX is not stalled: o_ifid_flush=o_idex_flush=1, stalls 0. The upstream block SHALL hold i_ex_redirect stable while EX is stalled.
REQ-013 Load-use: when i_ex_valid, i_ex_is_load, i_ex_rd!=0, i_id_valid and ((i_id_use_rs1 and rs1==rd) or (i_id_use_rs2 and rs2==rd)) are all true, outputs SHALL be o_pc_stall=o_ifid_stall=1 and o_idex_flush=1. Register x0 SHALL never produce a hazard.
REQ-014 When no condition is active, all stall, flush and abort outputs SHALL be 0.

Reset
REQ-015 When i_rst_n=0 at a rising edge, the block SHALL set state RUN, watchdog counter 0, o_mc_timeout=0 and o_stall_cycles=0. During reset all stalls, flushes and o_mc_abort SHALL be 0. Reset during MC_WAIT SHALL return to RUN with no abort pulse.

Configuration
REQ-016 With macro COTM32_HAZARD_PERF_EN defined:
- o_stall_cycles increments by 1 on every non-reset cycle with o_pc_stall=1;
- it wraps from 0xFFFFFFFF to 0.
Without the macro, o_stall_cycles SHALL be constant 0 and no counter flops SHALL be built.

Verification
REQ-017 Load x5 in EX, ID uses rs2=x5 -> one cycle of pc/ifid stall plus idex flush; with rd=x0 -> no stall.
REQ-018 mc_start in RUN, mc_done on the 4th cycle -> stalls and exmem flush for 3 cycles, o_state=1 for cycles 2-3, RUN at cycle 4.
REQ-019 MC_MAX_CYCLES=8, mc_done never asserted -> o_mc_abort pulses at cycle 8 of MC_WAIT, o_mc_timeout=1 and stays set, state RUN.
REQ-020 Trap during MC_WAIT with mem_busy=1 -> all three flushes, o_mc_abort=1, no stalls, next state RUN.
REQ-021 Redirect together with load-use hazard -> ifid/idex flush only, pc stall 0. With PERF_EN, 10 stall cycles -> o_stall_cycles=10; counter preset to 0xFFFFFFFF then one stall cycle -> 0.
